count_sequencer: RTL and testbench

- Command-driven controller that sequences the 21-bit event counter datapath in top_system.
- Decodes the 3-bit command bus into one-shot events and runs a start/pause/clear/limit FSM that drives the counter enable and clear.
- Captures count snapshots into a valid/ready output register.
- Exports FSM state as the 3-bit status word; the snapshot feeds the 12-bit data output.

---
 rtl/count_seq_pkg.sv | 23 ++
 rtl/count_sequencer_snap_holder.sv | 55 +++++
 rtl/count_sequencer.sv | 116 +++++++++++
 tb/tb_count_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared definitions for the count sequencer.
// Holds the FSM state encoding, the command bus codes and default widths.
package count_seq_pkg;

    localparam int unsigned CNT_W_DEF  = 21;
    localparam int unsigned SNAP_W_DEF = 12;

    // Encodings are visible on state_out, so they are fixed explicitly.
    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StRun   = 3'b001,
        StPause = 3'b010,
        StClear = 3'b011,
        StLimit = 3'b100
    } state_e;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_STOP  = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b100;
    localparam logic [2:0] CMD_SNAP  = 3'b111;

endpackage

// File: rtl/count_sequencer_snap_holder.sv
// snap_holder: single-entry valid/ready snapshot register.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load_req_i  - request to capture data_i this cycle
//   data_i      - value to capture
//   ready_i     - downstream accepts the held snapshot
//   valid_o     - snapshot held
//   data_o      - held snapshot
//   drop_o      - combinational: load requested while full and not draining
module snap_holder #(
    parameter int unsigned SNAP_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req_i,
    input  logic [SNAP_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [SNAP_W-1:0] data_o,
    output logic              drop_o
);

    logic              valid_q, valid_d;
    logic [SNAP_W-1:0] data_q, data_d;
    logic              load;

    // A full register may be reloaded in the same cycle it is drained.
    assign load   = load_req_i && (!valid_q || ready_i);
    assign drop_o = load_req_i && !load;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven controller for the event counter datapath.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   command     - 3-bit command bus; a held code yields one event
//   count       - current counter value from the datapath
//   snap_ready  - downstream accepts snapshot
//   cnt_en      - counter increment enable (RUN only)
//   cnt_clr     - counter synchronous clear (CLEAR only)
//   snap_valid  - snapshot held
//   snap_data   - captured count[SNAP_W-1:0]
//   state_out   - FSM state encoding
//   cmd_err     - one-cycle pulse on an illegal or dropped command
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned SNAP_W    = SNAP_W_DEF,
    parameter int unsigned MAX_COUNT = 2**CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        command,
    input  logic [CNT_W-1:0]  count,
    input  logic              snap_ready,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              snap_valid,
    output logic [SNAP_W-1:0] snap_data,
    output logic [2:0]        state_out,
    output logic              cmd_err
);

    // Leaving RUN one count early makes cnt_en fall on the edge count reaches MAX_COUNT.
    localparam logic [CNT_W-1:0] LIMIT_ARM = CNT_W'(MAX_COUNT - 1);

    state_e     state_q, state_d;
    logic [2:0] cmd_q;
    logic       cnt_en_q, cnt_clr_q, cmd_err_q, err_d;

    logic cmd_acc, ev_start, ev_stop, ev_clear, ev_snap, ev_illegal;
    logic limit_hit, fsm_err, snap_drop;

    assign cmd_acc    = (command != CMD_NOP) && (command != cmd_q);
    assign ev_start   = cmd_acc && (command == CMD_START);
    assign ev_stop    = cmd_acc && (command == CMD_STOP);
    assign ev_clear   = cmd_acc && (command == CMD_CLEAR);
    assign ev_snap    = cmd_acc && (command == CMD_SNAP);
    assign ev_illegal = cmd_acc && !(ev_start || ev_stop || ev_clear || ev_snap);
    assign limit_hit  = (state_q == StRun) && (count == LIMIT_ARM);

    always_comb begin
        state_d = state_q;
        fsm_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_start)      state_d = StRun;
                else if (ev_clear) state_d = StClear;
            end
            StRun: begin
                // CLEAR beats limit; limit beats STOP.
                if (ev_clear)       state_d = StClear;
                else if (limit_hit) state_d = StLimit;
                else if (ev_stop)   state_d = StPause;
            end
            StPause: begin
                if (ev_start)      state_d = StRun;
                else if (ev_clear) state_d = StClear;
            end
            StClear: begin
                state_d = StIdle;
                fsm_err = cmd_acc && !ev_snap;
            end
            StLimit: begin
                if (ev_clear)      state_d = StClear;
                else if (ev_start) fsm_err = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        err_d = fsm_err || ev_illegal || snap_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= CMD_NOP;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= command;
            cnt_en_q  <= (state_d == StRun);
            cnt_clr_q <= (state_d == StClear);
            cmd_err_q <= err_d;
        end
    end

    snap_holder #(
        .SNAP_W (SNAP_W)
    ) u_snap_holder (
        .clk        (clk),
        .rst        (rst),
        .load_req_i (ev_snap),
        .data_i     (count[SNAP_W-1:0]),
        .ready_i    (snap_ready),
        .valid_o    (snap_valid),
        .data_o     (snap_data),
        .drop_o     (snap_drop)
    );

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign cmd_err   = cmd_err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench for count_sequencer with MAX_COUNT=20
// and a model counter datapath driven by cnt_en/cnt_clr.
module tb_count_sequencer;

    localparam int unsigned CNT_W     = 21;
    localparam int unsigned SNAP_W    = 12;
    localparam int unsigned MAX_COUNT = 20;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_START = 3'b001;
    localparam logic [2:0] C_STOP  = 3'b010;
    localparam logic [2:0] C_CLEAR = 3'b100;
    localparam logic [2:0] C_SNAP  = 3'b111;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        command;
    logic [CNT_W-1:0]  count;
    logic              snap_ready;
    logic              cnt_en;
    logic              cnt_clr;
    logic              snap_valid;
    logic [SNAP_W-1:0] snap_data;
    logic [2:0]        state_out;
    logic              cmd_err;

    // Bench-side counter override, used to preload arbitrary count values.
    logic             load_req;
    logic [CNT_W-1:0] load_val;

    // Expected snapshot register contents, tracked by the stimulus code.
    logic              e_sv;
    logic [SNAP_W-1:0] e_sd;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]        st;
        logic              en;
        logic              clr;
        logic              sv;
        logic [SNAP_W-1:0] sd;
        logic              err;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];

    count_sequencer #(
        .CNT_W     (CNT_W),
        .SNAP_W    (SNAP_W),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .command    (command),
        .count      (count),
        .snap_ready (snap_ready),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .state_out  (state_out),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    // Model datapath counter.
    always @(posedge clk or posedge rst) begin
        if (rst)           count <= '0;
        else if (load_req) count <= load_val;
        else if (cnt_clr)  count <= '0;
        else if (cnt_en)   count <= count + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".st"},  32'(state_out),  32'd0);
        check({tag, ".en"},  32'(cnt_en),     32'd0);
        check({tag, ".clr"}, 32'(cnt_clr),    32'd0);
        check({tag, ".sv"},  32'(snap_valid), 32'd0);
        check({tag, ".sd"},  32'(snap_data),  32'd0);
        check({tag, ".err"}, 32'(cmd_err),    32'd0);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".st"},  32'(state_out),  32'(e.st));
        check({tag, ".en"},  32'(cnt_en),     32'(e.en));
        check({tag, ".clr"}, 32'(cnt_clr),    32'(e.clr));
        check({tag, ".sv"},  32'(snap_valid), 32'(e.sv));
        check({tag, ".sd"},  32'(snap_data),  32'(e.sd));
        check({tag, ".err"}, 32'(cmd_err),    32'(e.err));
        check({tag, ".cnt"}, 32'(count),      32'(e.cnt));
    endtask

    // Drive one cycle of stimulus, queue what the DUT must show after the edge.
    task automatic step(input string tag, input logic [2:0] cmd, input logic [2:0] st,
                        input logic en, input logic clr, input logic err,
                        input logic [CNT_W-1:0] cnt);
        exp_t e;
        command = cmd;
        e.st  = st;
        e.en  = en;
        e.clr = clr;
        e.sv  = e_sv;
        e.sd  = e_sd;
        e.err = err;
        e.cnt = cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        compare_out(tag);
    endtask

    initial begin
        rst        = 1'b1;
        command    = C_NOP;
        snap_ready = 1'b0;
        load_req   = 1'b0;
        load_val   = '0;
        e_sv       = 1'b0;
        e_sd       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // START held two cycles -> single event, then count ten cycles.
        step("start_0", C_START, 3'd1, 1, 0, 0, 21'd0);
        step("start_held", C_START, 3'd1, 1, 0, 0, 21'd1);
        step("run_2", C_NOP, 3'd1, 1, 0, 0, 21'd2);
        for (int i = 3; i <= 10; i++) step("run_n", C_NOP, 3'd1, 1, 0, 0, CNT_W'(i));
        step("stop", C_STOP, 3'd2, 0, 0, 0, 21'd11);
        step("stop_held", C_STOP, 3'd2, 0, 0, 0, 21'd11);
        step("pause_frozen", C_NOP, 3'd2, 0, 0, 0, 21'd11);

        // CLEAR, then a START landing in CLEAR is dropped.
        step("clear", C_CLEAR, 3'd3, 0, 1, 0, 21'd11);
        step("clr_drop", C_START, 3'd0, 0, 0, 1, 21'd0);
        step("idle", C_NOP, 3'd0, 0, 0, 0, 21'd0);

        // Run up to the terminal count.
        step("lim_start", C_START, 3'd1, 1, 0, 0, 21'd0);
        for (int k = 1; k <= 19; k++) step("lim_run", C_NOP, 3'd1, 1, 0, 0, CNT_W'(k));
        step("lim_hit", C_NOP, 3'd4, 0, 0, 0, 21'd20);
        step("lim_hold", C_NOP, 3'd4, 0, 0, 0, 21'd20);
        step("lim_start_err", C_START, 3'd4, 0, 0, 1, 21'd20);
        step("lim_err_end", C_NOP, 3'd4, 0, 0, 0, 21'd20);
        step("lim_stop", C_STOP, 3'd4, 0, 0, 0, 21'd20);
        step("lim_nop", C_NOP, 3'd4, 0, 0, 0, 21'd20);
        step("lim_clear", C_CLEAR, 3'd3, 0, 1, 0, 21'd20);
        step("lim_idle", C_NOP, 3'd0, 0, 0, 0, 21'd0);

        // Illegal codes in RUN, then STOP -> SNAP back to back.
        step("ill_start", C_START, 3'd1, 1, 0, 0, 21'd0);
        step("ill_011", 3'b011, 3'd1, 1, 0, 1, 21'd1);
        step("ill_101", 3'b101, 3'd1, 1, 0, 1, 21'd2);
        step("ill_110", 3'b110, 3'd1, 1, 0, 1, 21'd3);
        step("ill_end", C_NOP, 3'd1, 1, 0, 0, 21'd4);
        step("b2b_stop", C_STOP, 3'd2, 0, 0, 0, 21'd5);
        e_sv = 1'b1;
        e_sd = 12'h005;
        step("b2b_snap", C_SNAP, 3'd2, 0, 0, 0, 21'd5);
        step("b2b_hold", C_NOP, 3'd2, 0, 0, 0, 21'd5);
        snap_ready = 1'b1;
        e_sv = 1'b0;
        step("b2b_drain", C_NOP, 3'd2, 0, 0, 0, 21'd5);
        snap_ready = 1'b0;

        // Snapshot at 0xABC, second snapshot while full is dropped.
        load_req = 1'b1;
        load_val = 21'h00ABC;
        step("load_abc", C_NOP, 3'd2, 0, 0, 0, 21'h00ABC);
        e_sv = 1'b1;
        e_sd = 12'hABC;
        step("snap_abc", C_SNAP, 3'd2, 0, 0, 0, 21'h00ABC);
        load_req = 1'b1;
        load_val = 21'h00ABF;
        step("load_abf", C_NOP, 3'd2, 0, 0, 0, 21'h00ABF);
        step("snap_drop", C_SNAP, 3'd2, 0, 0, 1, 21'h00ABF);
        step("snap_drop_end", C_NOP, 3'd2, 0, 0, 0, 21'h00ABF);
        snap_ready = 1'b1;
        e_sv = 1'b0;
        step("snap_drain", C_NOP, 3'd2, 0, 0, 0, 21'h00ABF);
        snap_ready = 1'b0;

        // CLEAR accepted on the same edge as the limit.
        step("lc_clear0", C_CLEAR, 3'd3, 0, 1, 0, 21'h00ABF);
        step("lc_idle0", C_NOP, 3'd0, 0, 0, 0, 21'd0);
        step("lc_start", C_START, 3'd1, 1, 0, 0, 21'd0);
        for (int k = 1; k <= 19; k++) step("lc_run", C_NOP, 3'd1, 1, 0, 0, CNT_W'(k));
        step("lc_clear", C_CLEAR, 3'd3, 0, 1, 0, 21'd20);
        step("lc_idle", C_NOP, 3'd0, 0, 0, 0, 21'd0);

        // Reset mid-RUN with a snapshot pending.
        step("rr_start", C_START, 3'd1, 1, 0, 0, 21'd0);
        step("rr_run1", C_NOP, 3'd1, 1, 0, 0, 21'd1);
        step("rr_run2", C_NOP, 3'd1, 1, 0, 0, 21'd2);
        e_sv = 1'b1;
        e_sd = 12'h002;
        step("rr_snap", C_SNAP, 3'd1, 1, 0, 0, 21'd3);
        step("rr_run4", C_NOP, 3'd1, 1, 0, 0, 21'd4);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst  = 1'b0;
        e_sv = 1'b0;
        e_sd = '0;
        step("rr_after", C_NOP, 3'd0, 0, 0, 0, 21'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
